writeback_stage: RTL and testbench

//  - Writeback stage that drives the register file's single write port (we_reg/tgt/write_data).
//  - Merges ALU results, which arrive via valid/ready, with data-memory load returns, which are

---
 rtl/risc_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 72 +++++++
 rtl/writeback_stage.sv | 115 +++++++++++
 tb/tb_writeback_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared widths and the writeback entry type for the writeback stage.
package risc_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 2 ** REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] tgt;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] tgt_onehot(input logic [REG_AW-1:0] t);
        logic [NUM_REGS-1:0] oh;
        oh    = '0;
        oh[t] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of pending ALU writebacks; flush empties it at the edge.
// Per-entry valid and target vectors are exported so the top can build pend_mask.
module wb_fifo
    import risc_pkg::*;
#(
    parameter  int BUF_DEPTH = 2,
    localparam int PTR_W     = $clog2(BUF_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_push,
    input  wb_entry_t                         i_push_entry,
    input  logic                              i_pop,
    input  logic                              i_flush,
    output wb_entry_t                         o_head,
    output logic [CNT_W-1:0]                  o_count,
    output logic                              o_full,
    output logic                              o_empty,
    output logic [BUF_DEPTH-1:0]              o_valid,
    output logic [BUF_DEPTH-1:0][REG_AW-1:0]  o_tgt
);

    wb_entry_t            r_mem [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] r_valid;
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic                 w_push;
    logic                 w_pop;

    always_comb begin
        o_full  = (r_count == CNT_W'(BUF_DEPTH));
        o_empty = (r_count == '0);
        w_push  = i_push & ~o_full;
        w_pop   = i_pop & ~o_empty;
        o_count = r_count;
        o_valid = r_valid;
        o_head  = r_mem[r_rptr];
        for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            o_tgt[i] = r_mem[i].tgt;
        end
    end

    // Payload needs no reset: r_valid alone decides whether a slot is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_push_entry;
        end
    end

    // Pointers wrap naturally because BUF_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Register-file writeback: loads take priority, ALU results queue in wb_fifo.
// Optional macro WB_BYPASS_EN lets an ALU fire skip an empty FIFO (1-cycle latency).
module writeback_stage
    import risc_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [REG_AW-1:0]   alu_tgt,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                ld_valid,
    input  logic [REG_AW-1:0]   ld_tgt,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic                flush,
    output logic                we_reg,
    output logic [REG_AW-1:0]   tgt,
    output logic [DATA_W-1:0]   write_data,
    output logic [NUM_REGS-1:0] pend_mask
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic                              r_we;
    logic [REG_AW-1:0]                 r_tgt;
    logic [DATA_W-1:0]                 r_data;

    wb_entry_t                         w_head;
    wb_entry_t                         w_alu_entry;
    logic [CNT_W-1:0]                  w_count;
    logic                              w_full;
    logic                              w_empty;
    logic [BUF_DEPTH-1:0]              w_fifo_valid;
    logic [BUF_DEPTH-1:0][REG_AW-1:0]  w_fifo_tgt;
    logic                              w_fire;
    logic                              w_ld;
    logic                              w_pop;
    logic                              w_byp;
    logic                              w_push;
    logic [NUM_REGS-1:0]               w_pend;

    always_comb begin
        alu_ready   = rst_n & (w_count < CNT_W'(BUF_DEPTH));
        w_fire      = alu_valid & alu_ready;
        w_ld        = ld_valid & (ld_tgt != '0);
        w_pop       = ~w_empty & ~flush & ~w_ld;
`ifdef WB_BYPASS_EN
        w_byp       = w_fire & (alu_tgt != '0) & w_empty & ~w_ld & ~flush;
`else
        w_byp       = 1'b0;
`endif
        // Target-0 fires are consumed here and never reach the FIFO.
        w_push      = w_fire & (alu_tgt != '0) & ~flush & ~w_byp & ~w_full;
        w_alu_entry = '{tgt: alu_tgt, data: alu_data};
    end

    wb_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_entry (w_alu_entry),
        .i_pop        (w_pop),
        .i_flush      (flush),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_valid      (w_fifo_valid),
        .o_tgt        (w_fifo_tgt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_tgt  <= '0;
            r_data <= '0;
        end else if (w_ld) begin
            r_we   <= 1'b1;
            r_tgt  <= ld_tgt;
            r_data <= ld_data;
        end else if (w_pop) begin
            r_we   <= 1'b1;
            r_tgt  <= w_head.tgt;
            r_data <= w_head.data;
        end else if (w_byp) begin
            r_we   <= 1'b1;
            r_tgt  <= alu_tgt;
            r_data <= alu_data;
        end else begin
            r_we   <= 1'b0;
        end
    end

    always_comb begin
        w_pend = '0;
        for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            if (w_fifo_valid[i]) begin
                w_pend = w_pend | tgt_onehot(w_fifo_tgt[i]);
            end
        end
        if (r_we) begin
            w_pend = w_pend | tgt_onehot(r_tgt);
        end
    end

    assign we_reg     = r_we;
    assign tgt        = r_tgt;
    assign write_data = r_data;
    assign pend_mask  = w_pend;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: loads expected on an exact cycle, ALU
// results expected in fire order; a negedge monitor checks every write.
module tb_writeback_stage;
    import risc_pkg::*;

`ifdef WB_BYPASS_EN
    localparam int ALU_LAT = 1;
`else
    localparam int ALU_LAT = 2;
`endif

    typedef struct {
        int                cyc;
        logic [REG_AW-1:0] tgt;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                alu_valid;
    logic                alu_ready;
    logic [REG_AW-1:0]   alu_tgt;
    logic [DATA_W-1:0]   alu_data;
    logic                ld_valid;
    logic [REG_AW-1:0]   ld_tgt;
    logic [DATA_W-1:0]   ld_data;
    logic                flush;
    logic                we_reg;
    logic [REG_AW-1:0]   tgt;
    logic [DATA_W-1:0]   write_data;
    logic [NUM_REGS-1:0] pend_mask;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t ld_q[$];
    exp_t alu_q[$];

    writeback_stage #(
        .BUF_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_tgt    (alu_tgt),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_tgt     (ld_tgt),
        .ld_data    (ld_data),
        .flush      (flush),
        .we_reg     (we_reg),
        .tgt        (tgt),
        .write_data (write_data),
        .pend_mask  (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: a load due this cycle must be on the port; any other write is the next ALU result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (ld_q.size() > 0 && ld_q[0].cyc == cyc) begin
                e = ld_q.pop_front();
                chk("ld_we", 32'(we_reg), 32'd1);
                chk("ld_tgt", 32'(tgt), 32'(e.tgt));
                chk("ld_data", 32'(write_data), 32'(e.data));
            end else if (we_reg === 1'b1) begin
                if (alu_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write got tgt=%0h data=%0h want no write (cyc %0d)",
                             tgt, write_data, cyc);
                end else begin
                    e = alu_q.pop_front();
                    chk("alu_tgt", 32'(tgt), 32'(e.tgt));
                    chk("alu_data", 32'(write_data), 32'(e.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic issue_ld(input logic [REG_AW-1:0] t, input logic [DATA_W-1:0] d);
        exp_t e;
        ld_valid = 1'b1;
        ld_tgt   = t;
        ld_data  = d;
        if (t != '0) begin
            e = '{cyc + 1, t, d};
            ld_q.push_back(e);
        end
    endtask

    task automatic issue_alu(input logic [REG_AW-1:0] t, input logic [DATA_W-1:0] d,
                             input bit expect_write);
        exp_t e;
        alu_valid = 1'b1;
        alu_tgt   = t;
        alu_data  = d;
        if (expect_write) begin
            e = '{0, t, d};
            alu_q.push_back(e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_rdy [6];
        int ai;
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset with both sources active
        rst_n = 1'b0; flush = 1'b0;
        alu_valid = 1'b1; alu_tgt = 3'd1; alu_data = 16'h1111;
        ld_valid  = 1'b1; ld_tgt  = 3'd5; ld_data  = 16'h5555;
        #1;
        chk("rst_ready_pre", 32'(alu_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_we", 32'(we_reg), 32'd0);
            chk("rst_ready", 32'(alu_ready), 32'd0);
            chk("rst_pend", 32'(pend_mask), 32'd0);
        end
        chk("rst_tgt", 32'(tgt), 32'd0);
        chk("rst_data", 32'(write_data), 32'd0);
        rst_n = 1'b1;
        idle();
        #1;
        chk("rel_ready", 32'(alu_ready), 32'd1);

        // Single ALU result and its latency
        step();
        issue_alu(3'd3, 16'h1234, 1'b1);
        step();
        idle();
        for (int k = 1; k <= ALU_LAT; k++) begin
            chk("lat_we", 32'(we_reg), 32'(k == ALU_LAT));
            chk("lat_pend3", 32'(pend_mask[3]), 32'd1);
            step();
        end
        chk("lat_we_after", 32'(we_reg), 32'd0);
        chk("lat_pend_after", 32'(pend_mask), 32'd0);

        // Load overtakes a buffered ALU result
        issue_ld(3'd7, 16'h0707);
        issue_alu(3'd2, 16'h0002, 1'b1);
        step();
        idle();
        chk("prio_pend", 32'(pend_mask), 32'h84);
        issue_ld(3'd5, 16'hBEEF);
        step();
        idle();
        chk("prio_ld_tgt", 32'(tgt), 32'd5);
        step();
        chk("prio_alu_we", 32'(we_reg), 32'd1);
        chk("prio_alu_tgt", 32'(tgt), 32'd2);
        step();

        // Backpressure: loads stall pops until the FIFO fills
        ai = 0;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) issue_ld(3'd6, 16'h6000 + 16'(c));
            else       ld_valid = 1'b0;
            if (ai < 3) begin
                alu_valid = 1'b1;
                alu_tgt   = 3'(ai + 1);
                alu_data  = 16'(16'h1111 * (ai + 1));
                chk("bp_ready", 32'(alu_ready), 32'(exp_rdy[c]));
                if (exp_rdy[c]) begin
                    issue_alu(3'(ai + 1), 16'(16'h1111 * (ai + 1)), 1'b1);
                    ai++;
                end
            end else begin
                alu_valid = 1'b0;
            end
            step();
        end
        idle();
        step();
        step();

        // Target 0 is swallowed on both sources
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_tgt = 3'd0; alu_data = 16'hAAAA;
            issue_ld(3'd0, 16'h5555);
            chk("t0_ready", 32'(alu_ready), 32'd1);
            chk("t0_pend", 32'(pend_mask), 32'd0);
            step();
            chk("t0_we", 32'(we_reg), 32'd0);
        end
        idle();

        // Flush of a full FIFO with an ALU offer pending
        issue_ld(3'd7, 16'h0077);
        issue_alu(3'd1, 16'h0101, 1'b0);
        step();
        issue_ld(3'd7, 16'h0078);
        issue_alu(3'd2, 16'h0202, 1'b0);
        chk("fl_ready_b", 32'(alu_ready), 32'd1);
        step();
        ld_valid = 1'b0;
        flush    = 1'b1;
        issue_alu(3'd4, 16'h0404, 1'b0);
        chk("fl_full_ready", 32'(alu_ready), 32'd0);
        chk("fl_pend_pre", 32'(pend_mask), 32'h86);
        step();
        idle();
        chk("fl_we", 32'(we_reg), 32'd0);
        chk("fl_pend", 32'(pend_mask), 32'd0);
        chk("fl_ready", 32'(alu_ready), 32'd1);

        // Flush with a real ALU fire and a concurrent load
        issue_ld(3'd7, 16'h0079);
        issue_alu(3'd1, 16'h0111, 1'b0);
        step();
        flush = 1'b1;
        issue_ld(3'd5, 16'h0505);
        issue_alu(3'd4, 16'h0404, 1'b0);
        chk("fl2_ready_pre", 32'(alu_ready), 32'd1);
        step();
        idle();
        chk("fl2_pend", 32'(pend_mask), 32'h20);
        chk("fl2_ready", 32'(alu_ready), 32'd1);
        chk("fl2_tgt", 32'(tgt), 32'd5);
        step();
        chk("fl2_pend_after", 32'(pend_mask), 32'd0);
        chk("fl2_we_after", 32'(we_reg), 32'd0);

        for (int i = 0; i < 20 && (ld_q.size() + alu_q.size()) != 0; i++) step();
        step();
        chk("queues_drained", 32'(ld_q.size() + alu_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
